// File: rtl/row_window_reader.sv
// Row line-buffer controller: write/read sequencing for two row RAMs plus a registered 3x3 RGB window.
// Latency 2 cycles pixel->window; no backpressure, consumer must take every win_valid. Optional LINE_ERR_EN adds line_err.
// Sync active-low reset; row1 holds line y-1, row2 holds line y-2 (aged from row1 read data).
module row_window_reader #(
    parameter int DW       = 24,
    parameter int H_ACTIVE = 640,
    parameter int AW       = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   pix_in,
    input  logic            pix_valid,
    input  logic            sof,
    output logic [AW-1:0]   ram_rd_adr,
    output logic            row1_wr_en,
    output logic [AW-1:0]   row1_wr_adr,
    output logic [DW-1:0]   row1_wr_data,
    input  logic [DW-1:0]   row1_q,
    output logic            row2_wr_en,
    output logic [AW-1:0]   row2_wr_adr,
    output logic [DW-1:0]   row2_wr_data,
    input  logic [DW-1:0]   row2_q,
    output logic [9*DW-1:0] win_out,
    output logic            win_valid,
    output logic [AW-1:0]   win_x
`ifdef LINE_ERR_EN
    ,
    output logic            line_err
`endif
);

    localparam logic [AW-1:0] X_LAST = AW'(H_ACTIVE - 1);

    logic [AW-1:0] x_cnt;
    logic [1:0]    row_cnt;

    logic          take_sof;
    logic [AW-1:0] cur_x;
    logic [1:0]    cur_row;

    logic          s1_valid;
    logic [DW-1:0] s1_pix;
    logic [AW-1:0] s1_x;
    logic [1:0]    s1_row;

    // A qualified sof re-homes the current pixel to (0,0) before it is written.
    assign take_sof = pix_valid & sof;
    assign cur_x    = take_sof ? '0 : x_cnt;
    assign cur_row  = take_sof ? 2'd0 : row_cnt;

    assign ram_rd_adr   = cur_x;
    assign row1_wr_en   = pix_valid & rst_n;
    assign row1_wr_adr  = cur_x;
    assign row1_wr_data = pix_in;

    assign row2_wr_en   = s1_valid & rst_n;
    assign row2_wr_adr  = s1_x;
    assign row2_wr_data = row1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt   <= '0;
            row_cnt <= 2'd0;
        end else if (pix_valid) begin
            if (cur_x == X_LAST) begin
                x_cnt   <= '0;
                row_cnt <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
            end else begin
                x_cnt   <= cur_x + AW'(1);
                row_cnt <= cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_x     <= '0;
            s1_row   <= 2'd0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_pix <= pix_in;
                s1_x   <= cur_x;
                s1_row <= cur_row;
            end
        end
    end

    // Columns shift left on each stage-1 pixel; new right column is {y-2, y-1, y} top to bottom.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_out   <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
        end else begin
            win_valid <= s1_valid && (s1_x >= AW'(2)) && (s1_row == 2'd2);
            if (s1_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_out[(r*3+0)*DW +: DW] <= win_out[(r*3+1)*DW +: DW];
                    win_out[(r*3+1)*DW +: DW] <= win_out[(r*3+2)*DW +: DW];
                end
                win_out[2*DW +: DW] <= row2_q;
                win_out[5*DW +: DW] <= row1_q;
                win_out[8*DW +: DW] <= s1_pix;
                win_x               <= s1_x - AW'(1);
            end
        end
    end

`ifdef LINE_ERR_EN
    // Sticky: a frame restarted part-way through a line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_err <= 1'b0;
        end else if (take_sof && (x_cnt != '0)) begin
            line_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_row_window_reader.sv
// Bench for row_window_reader: small-line instance (H_ACTIVE=8) checked by a window scoreboard,
// plus a default-width instance for RAM address/aging behaviour at the 640-pixel wrap.
module tb_row_window_reader;
    localparam int DW = 24;
    localparam int AW = 10;
    localparam int HS = 8;
    localparam int WW = 9 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [DW-1:0] pix_in;
    logic          pix_valid, sof;
    logic [AW-1:0] rd_adr, r1_wa, r2_wa, win_x;
    logic          r1_we, r2_we, win_valid;
    logic [DW-1:0] r1_wd, r2_wd, r1_q, r2_q;
    logic [WW-1:0] win_out;

    logic [DW-1:0] b_pix;
    logic          b_valid, b_sof;
    logic [AW-1:0] b_rd_adr, b_r1_wa, b_r2_wa, b_win_x;
    logic          b_r1_we, b_r2_we, b_win_valid;
    logic [DW-1:0] b_r1_wd, b_r2_wd, b_r1_q, b_r2_q;
    logic [WW-1:0] b_win_out;
`ifdef LINE_ERR_EN
    logic          line_err, b_line_err;
`endif

    row_window_reader #(.DW(DW), .H_ACTIVE(HS), .AW(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .ram_rd_adr(rd_adr),
        .row1_wr_en(r1_we), .row1_wr_adr(r1_wa), .row1_wr_data(r1_wd), .row1_q(r1_q),
        .row2_wr_en(r2_we), .row2_wr_adr(r2_wa), .row2_wr_data(r2_wd), .row2_q(r2_q),
        .win_out(win_out), .win_valid(win_valid), .win_x(win_x)
`ifdef LINE_ERR_EN
        , .line_err(line_err)
`endif
    );

    row_window_reader u_big (
        .clk(clk), .rst_n(rst_n), .pix_in(b_pix), .pix_valid(b_valid), .sof(b_sof),
        .ram_rd_adr(b_rd_adr),
        .row1_wr_en(b_r1_we), .row1_wr_adr(b_r1_wa), .row1_wr_data(b_r1_wd), .row1_q(b_r1_q),
        .row2_wr_en(b_r2_we), .row2_wr_adr(b_r2_wa), .row2_wr_data(b_r2_wd), .row2_q(b_r2_q),
        .win_out(b_win_out), .win_valid(b_win_valid), .win_x(b_win_x)
`ifdef LINE_ERR_EN
        , .line_err(b_line_err)
`endif
    );

    // Row RAMs: 1-cycle read latency, read-before-write on the same address.
    logic [DW-1:0] m1 [0:1023];
    logic [DW-1:0] m2 [0:1023];
    logic [DW-1:0] bm1 [0:1023];
    logic [DW-1:0] bm2 [0:1023];
    always @(posedge clk) begin
        r1_q   <= m1[rd_adr];
        r2_q   <= m2[rd_adr];
        b_r1_q <= bm1[b_rd_adr];
        b_r2_q <= bm2[b_rd_adr];
        if (r1_we)   m1[r1_wa]    <= r1_wd;
        if (r2_we)   m2[r2_wa]    <= r2_wd;
        if (b_r1_we) bm1[b_r1_wa] <= b_r1_wd;
        if (b_r2_we) bm2[b_r2_wa] <= b_r2_wd;
    end

    typedef struct {
        logic [WW-1:0] win;
        logic [AW-1:0] x;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int win_seen = 0;
    int m_x = 0;
    int m_y = 0;
    bit hold_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Small-DUT stimulus; pixel value = {frame row, x}, expected window derived from coordinates.
    task automatic drive_pix(input bit v, input bit s);
        exp_t e;
        @(negedge clk);
        pix_valid = v;
        sof       = s;
        if (v) begin
            if (s) begin
                m_x = 0;
                m_y = 0;
            end
            pix_in = {m_y[11:0], m_x[11:0]};
            if (m_y >= 2 && m_x >= 2) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.win[(r*3+c)*DW +: DW] = {12'(m_y - 2 + r), 12'(m_x - 2 + c)};
                e.x   = AW'(m_x - 1);
                e.cyc = cyc + 2;
                sb.push_back(e);
            end
            m_x++;
            if (m_x == HS) begin
                m_x = 0;
                m_y++;
            end
        end else begin
            pix_in = DW'($urandom);
        end
    endtask

    task automatic drain(input string name);
        repeat (4) drive_pix(1'b0, 1'($urandom_range(0, 1)));
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_windows: %0d expected windows never appeared, want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b1;
        sof       = 1'b0;
        pix_in    = DW'($urandom);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (r1_we !== 1'b0) begin
                failures++;
                $display("FAIL reset_row1_wr_en: got %b want 0", r1_we);
            end
        end
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        m_x = 0;
        m_y = 0;
    endtask

    // Scoreboard consumer, plus hold check between windows when enabled.
    logic [WW-1:0] last_win;
    bit            last_vld = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (win_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_window: win_valid=1 win_x=%0d at cycle %0d, want no window", win_x, cyc);
            end else begin
                e = sb.pop_front();
                win_seen++;
                checks++;
                if (win_out !== e.win || win_x !== e.x || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL window: got x=%0d cyc=%0d win=%h, want x=%0d cyc=%0d win=%h",
                             win_x, cyc, win_out, e.x, e.cyc, e.win);
                end
            end
        end else if (hold_en && last_vld) begin
            checks++;
            if (win_out !== last_win) begin
                failures++;
                $display("FAIL window_hold: got %h want %h", win_out, last_win);
            end
        end
        last_win = win_out;
        last_vld = win_valid;
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        pix_valid = 1'b1;
        sof       = 1'b0;
        pix_in    = 24'h123456;
        b_valid   = 1'b0;
        b_sof     = 1'b0;
        b_pix     = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks += 4;
            if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
            if (r1_we !== 1'b0)     begin failures++; $display("FAIL reset_row1_wr_en: got %b want 0", r1_we); end
            if (r2_we !== 1'b0)     begin failures++; $display("FAIL reset_row2_wr_en: got %b want 0", r2_we); end
            if (win_out !== '0)     begin failures++; $display("FAIL reset_win_out: got %h want 0", win_out); end
        end
        @(negedge clk);
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        m_x = 0;
        m_y = 0;
    endtask

    task automatic test_full_frame();
        int base = win_seen;
        drive_pix(1'b1, 1'b1);
        repeat (3 * HS - 1) drive_pix(1'b1, 1'b0);
        drain("full_frame");
        checks++;
        if (win_seen - base != 6) begin
            failures++;
            $display("FAIL full_frame_count: got %0d windows want 6", win_seen - base);
        end
    endtask

    task automatic test_gaps();
        int base = win_seen;
        hold_en = 1'b1;
        for (int i = 0; i < 3 * HS; i++) begin
            drive_pix(1'b1, i == 0);
            drive_pix(1'b0, 1'($urandom_range(0, 1)));
        end
        drain("gaps");
        hold_en = 1'b0;
        checks++;
        if (win_seen - base != 6) begin
            failures++;
            $display("FAIL gaps_count: got %0d windows want 6", win_seen - base);
        end
    endtask

    task automatic test_wide_line();
        logic [AW-1:0] prev_wa;
        int            prev_x;
        prev_wa = '0;
        prev_x  = -1;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 640; x++) begin
                @(negedge clk);
                if (y == 1 && (prev_x == 0 || prev_x == 1 || prev_x == 320 || prev_x == 638)) begin
                    checks += 3;
                    if (b_r2_we !== 1'b1) begin failures++; $display("FAIL wide_row2_wr_en x=%0d: got %b want 1", prev_x, b_r2_we); end
                    if (b_r2_wa !== prev_wa) begin failures++; $display("FAIL wide_row2_wr_adr x=%0d: got %0d want %0d", prev_x, b_r2_wa, prev_wa); end
                    if (b_r2_wd !== (24'hA00000 | DW'(prev_x))) begin
                        failures++;
                        $display("FAIL wide_row2_wr_data x=%0d: got %h want %h", prev_x, b_r2_wd, 24'hA00000 | DW'(prev_x));
                    end
                end
                b_valid = 1'b1;
                b_sof   = (x == 0 && y == 0);
                b_pix   = ((y == 0) ? 24'hA00000 : 24'hB00000) | DW'(x);
                #1;
                prev_wa = b_r1_wa;
                prev_x  = (y == 1) ? x : -1;
                if ((y == 0 && x == 639) || (y == 1 && x == 0)) begin
                    checks += 2;
                    if (b_rd_adr !== AW'(x)) begin failures++; $display("FAIL wide_rd_adr y=%0d x=%0d: got %0d want %0d", y, x, b_rd_adr, x); end
                    if (b_r1_wa !== AW'(x))  begin failures++; $display("FAIL wide_row1_wr_adr y=%0d x=%0d: got %0d want %0d", y, x, b_r1_wa, x); end
                end
            end
        end
        @(negedge clk);
        b_valid = 1'b0;
        b_sof   = 1'b0;
        checks += 2;
        if (b_r2_wa !== 10'd639) begin failures++; $display("FAIL wide_row2_last_adr: got %0d want 639", b_r2_wa); end
        if (b_r2_wd !== 24'hA0027F) begin failures++; $display("FAIL wide_row2_last_data: got %h want a0027f", b_r2_wd); end
    endtask

    task automatic test_sof_restart();
        int base = win_seen;
        drive_pix(1'b1, 1'b1);
        repeat (3 * HS + 4) drive_pix(1'b1, 1'b0);
        drive_pix(1'b1, 1'b1);
        repeat (3 * HS - 1) drive_pix(1'b1, 1'b0);
        drain("sof_restart");
        checks++;
        if (win_seen - base != 15) begin
            failures++;
            $display("FAIL sof_restart_count: got %0d windows want 15", win_seen - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        drive_pix(1'b1, 1'b1);
        repeat (HS + 3) drive_pix(1'b1, 1'b0);
        drain("reset_mid_pre");
        do_reset();
        base = win_seen;
        repeat (3 * HS) drive_pix(1'b1, 1'b0);
        drain("reset_mid");
        checks++;
        if (win_seen - base != 6) begin
            failures++;
            $display("FAIL reset_mid_count: got %0d windows want 6", win_seen - base);
        end
    endtask

`ifdef LINE_ERR_EN
    task automatic test_line_err();
        do_reset();
        drive_pix(1'b1, 1'b1);
        repeat (HS - 1) drive_pix(1'b1, 1'b0);
        drive_pix(1'b1, 1'b1);
        repeat (2) drive_pix(1'b1, 1'b0);
        drain("line_err_clean");
        checks++;
        if (line_err !== 1'b0) begin failures++; $display("FAIL line_err_clean: got %b want 0", line_err); end
        do_reset();
        drive_pix(1'b1, 1'b1);
        repeat (4) drive_pix(1'b1, 1'b0);
        drive_pix(1'b1, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (line_err !== 1'b1) begin failures++; $display("FAIL line_err_set: got %b want 1", line_err); end
        repeat (6) drive_pix(1'b1, 1'b0);
        drain("line_err_sticky");
        checks++;
        if (line_err !== 1'b1) begin failures++; $display("FAIL line_err_sticky: got %b want 1", line_err); end
        do_reset();
        checks++;
        if (line_err !== 1'b0) begin failures++; $display("FAIL line_err_reset: got %b want 0", line_err); end
    endtask
`endif

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL timeout: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_wide_line();
        test_sof_restart();
        test_reset_mid();
`ifdef LINE_ERR_EN
        test_line_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
